// File: rtl/spi_slave_rx_pkg.sv
// SPI slave receiver shared types.
// FSM encodings, SPI mode constants and the clock ratio check.
package spi_slave_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // SPI mode 0: sck idles low, sample on rising edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Oversampling needs at least 4 clk_i per sck period
  function automatic bit ratio_ok(int clk_fre, int spi_fre);
    return clk_fre >= 4 * spi_fre;
  endfunction

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// Small synchronous FIFO with a registered head word.
// Head holds its last value once the FIFO drains.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wr_q, rd_q, occ;
  logic [AW-1:0]     rd_nxt;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_pop, do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign occ     = wr_q - rd_q;
  assign rd_nxt  = rd_q[AW-1:0] + 1'b1;
  assign rdata_o = head_q;

  // Next head: following entry on pop, or incoming word when it lands first
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (occ > 1)
        head_d = mem_q[rd_nxt];
      else if (do_push)
        head_d = wdata_i;
    end else if (empty_o && do_push) begin
      head_d = wdata_i;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  // Pointers and head register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode 0 slave receiver, oversampled in clk_i.
// Deserialises MSB-first words into a FIFO with a valid/ready output.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int SPI_FRE    = 10,
  parameter int CLK_FRE    = 100,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_sdo,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              ovf_flag,
  input  logic              ovf_clr
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  if (!ratio_ok(CLK_FRE, SPI_FRE)) begin : g_ratio_chk
    $error("spi_slave_rx: CLK_FRE must be >= 4*SPI_FRE");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("spi_slave_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic cs_m_q, cs_s_q;
  logic sck_m_q, sck_s_q, sck_d_q;
  logic sdo_m_q, sdo_s_q;
  logic sck_rise;

  state_e            state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] sr_q, shifted;
  logic              push_q, ferr_q, ovf_q;
  logic              last_bit, fifo_full, fifo_empty;

  // Two-flop synchronisers plus one delay stage on sck for edge detect
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cs_m_q  <= 1'b1;
      cs_s_q  <= 1'b1;
      sck_m_q <= SPI_CPOL;
      sck_s_q <= SPI_CPOL;
      sck_d_q <= SPI_CPOL;
      sdo_m_q <= 1'b0;
      sdo_s_q <= 1'b0;
    end else begin
      cs_m_q  <= spi_cs;
      cs_s_q  <= cs_m_q;
      sck_m_q <= spi_sck;
      sck_s_q <= sck_m_q;
      sck_d_q <= sck_s_q;
      sdo_m_q <= spi_sdo;
      sdo_s_q <= sdo_m_q;
    end
  end

  assign sck_rise = sck_s_q & ~sck_d_q;
  assign last_bit = (bit_cnt_q == CW'(DATA_W - 1));
  assign shifted  = {sr_q[DATA_W-2:0], sdo_s_q};

  // Frame FSM with shift register; push and frame error are registered
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          if (!cs_s_q) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_s_q) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            if (sck_rise && last_bit) begin
              sr_q   <= shifted;
              push_q <= 1'b1;
            end else begin
              ferr_q <= (bit_cnt_q != '0);
            end
          end else if (sck_rise) begin
            sr_q      <= shifted;
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            push_q    <= last_bit;
          end
        end
      endcase
    end
  end

  // Sticky overflow: set on a dropped word, set beats clear
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (push_q && fifo_full && !rx_ready)
      ovf_q <= 1'b1;
    else if (ovf_clr)
      ovf_q <= 1'b0;
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .wdata_i (sr_q),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = ferr_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx.
// Stimulus queues expected words; a negedge monitor checks pops.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs, spi_sck, spi_sdo;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       frame_err, ovf_flag, ovf_clr;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscmp  = 0;
  int fe_cnt  = 0;

  always #5 clk = ~clk;

  spi_slave_rx #(
    .SPI_FRE(10), .CLK_FRE(100), .DATA_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_n(rst_n),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_sdo(spi_sdo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: frame_err cycles and popped words against the queue
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscmp++;
          $display("FAIL unexpected_pop: got 0x%0h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e});
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    cyc(5);
  endtask

  // Shifts n bits MSB first; returns right after the last sck rise
  task automatic shift_word(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      if (spi_sck) begin
        cyc(5);
        spi_sck = 1'b0;
      end
      spi_sdo = d[7-i];
      cyc(5);
      spi_sck = 1'b1;
    end
  endtask

  task automatic cs_end();
    if (spi_sck) begin
      cyc(5);
      spi_sck = 1'b0;
    end
    cyc(5);
    spi_cs = 1'b1;
    cyc(10);
  endtask

  task automatic drain(int n);
    rx_ready = 1'b1;
    cyc(n);
    rx_ready = 1'b0;
    cyc(2);
  endtask

  task automatic check_idle_outs(string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_ovf_flag"}, {31'd0, ovf_flag}, 32'd0);
  endtask

  logic [7:0] burst [4];
  logic [7:0] ovfw  [5];
  logic [7:0] fullw [5];
  int fe_save;

  initial begin
    burst = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    ovfw  = '{8'h0F, 8'h33, 8'hC3, 8'hAA, 8'h55};
    fullw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    rst_n = 1'b0; rx_ready = 1'b0; ovf_clr = 1'b0;
    spi_cs = 1'b1; spi_sck = 1'b0; spi_sdo = 1'b0;

    // Reset with wires toggling
    for (int i = 0; i < 5; i++) begin
      spi_cs = ~spi_cs; spi_sck = ~spi_sck; spi_sdo = ~spi_sdo;
      cyc(1);
    end
    @(negedge clk);
    check_idle_outs("reset");
    spi_cs = 1'b1; spi_sck = 1'b0; spi_sdo = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    check_idle_outs("post_reset");

    // Single word with latency check
    exp_q.push_back(8'hA5);
    cs_begin();
    shift_word(8'hA5, 8);
    repeat (4) @(negedge clk);
    check("lat_valid_3clk", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid_4clk", {31'd0, rx_valid}, 32'd1);
    check("single_head", {24'd0, rx_data}, 32'hA5);
    cs_end();
    drain(1);
    check("single_empty", {31'd0, rx_valid}, 32'd0);
    check("single_hold", {24'd0, rx_data}, 32'hA5);

    // Burst of four under one cs, fill then drain
    cs_begin();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(burst[i]);
      shift_word(burst[i], 8);
    end
    cs_end();
    check("burst_valid", {31'd0, rx_valid}, 32'd1);
    check("burst_ovf", {31'd0, ovf_flag}, 32'd0);
    drain(4);
    check("burst_empty", {31'd0, rx_valid}, 32'd0);
    check("burst_fe", fe_cnt, 0);

    // Overflow: fifth word dropped
    cs_begin();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(ovfw[i]);
      shift_word(ovfw[i], 8);
    end
    cs_end();
    check("ovf_set", {31'd0, ovf_flag}, 32'd1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    cyc(1);
    check("ovf_clr", {31'd0, ovf_flag}, 32'd0);
    drain(4);
    check("ovf_empty", {31'd0, rx_valid}, 32'd0);

    // Full FIFO with push and pop in the same cycle
    cs_begin();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(fullw[i]);
      shift_word(fullw[i], 8);
    end
    cyc(3);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    cs_end();
    check("fullpp_ovf", {31'd0, ovf_flag}, 32'd0);
    check("fullpp_qlen", exp_q.size(), 4);
    drain(4);
    check("fullpp_empty", {31'd0, rx_valid}, 32'd0);

    // Frame error after 5 bits, then clean word
    cs_begin();
    shift_word(8'hE8, 5);
    cs_end();
    check("ferr_pulse", fe_cnt, 1);
    check("ferr_nopush", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back(8'h3C);
    cs_begin();
    shift_word(8'h3C, 8);
    cs_end();
    check("ferr_fe_stable", fe_cnt, 1);
    drain(1);

    // Reset mid-word
    fe_save = fe_cnt;
    cs_begin();
    shift_word(8'hFF, 3);
    rst_n = 1'b0;
    cyc(2);
    @(negedge clk);
    check_idle_outs("midreset");
    spi_cs = 1'b1; spi_sck = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(10);
    check("midreset_fe", fe_cnt, fe_save);
    check("midreset_valid", {31'd0, rx_valid}, 32'd0);

    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
